r5p_wbu: RTL

- Writeback unit directly upstream of the 2-read/1-write GPR file; sole driver of its write port (e_rd, a_rd, d_rd).
- Merges ALU/CSR results from execute with asynchronous load responses from the LSU.
- Aligns and sign/zero-extends load data.
- Tracks the single outstanding load in a scoreboard and tells decode when to stall on load-use and write-after-write hazards.

---
 rtl/r5p_wbu_pkg.sv | 25 ++
 rtl/r5p_load_align.sv | 30 +++
 rtl/r5p_wbu.sv | 108 ++++++++++
 3 files changed

// File: rtl/r5p_wbu_pkg.sv
// rtl/r5p_wbu_pkg.sv - shared types for the r5p writeback unit
package r5p_wbu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_f3_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wbu_state_t;

  // rd is sized for the widest GPR file (RV32I); RV32E uses the low 4 bits
  typedef struct packed {
    logic       we;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } pend_t;

endpackage

// File: rtl/r5p_load_align.sv
// rtl/r5p_load_align.sv - selects and extends the loaded byte/half/word
module r5p_load_align
  import r5p_wbu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] ld_dat,
  output logic [31:0] dat,
  output logic        ill
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b   = ld_dat[{off, 3'b000} +: 8];
    h   = ld_dat[{off[1], 4'b0000} +: 16];
    dat = '0;
    ill = 1'b0;
    case (f3)
      LB:      dat = {{24{b[7]}}, b};
      LBU:     dat = {24'h0, b};
      LH:      dat = {{16{h[15]}}, h};
      LHU:     dat = {16'h0, h};
      LW:      dat = ld_dat;
      default: ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/r5p_wbu.sv
// rtl/r5p_wbu.sv - GPR writeback: merges execute results with load responses
module r5p_wbu
  import r5p_wbu_pkg::*;
#(
  parameter int AW   = 5,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_vld,
  output logic            ex_rdy,
  input  logic            ex_wen,
  input  logic            ex_ld,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_dat,
  input  logic [2:0]      ex_f3,
  input  logic [1:0]      ex_off,
  input  logic            ld_vld,
  input  logic [XLEN-1:0] ld_dat,
  input  logic            id_e_rs1,
  input  logic            id_e_rs2,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  output logic            id_stall,
  output logic            ld_err,
  output logic            e_rd,
  output logic [AW-1:0]   a_rd,
  output logic [XLEN-1:0] d_rd
);

  wbu_state_t    state;
  pend_t         pend;
  logic [AW-1:0] pend_rd;
  logic [31:0]   al_dat;
  logic          al_ill;
  logic          wait_st;
  logic          ex_acc;

  r5p_load_align u_align (
    .f3     (pend.f3),
    .off    (pend.off),
    .ld_dat (ld_dat),
    .dat    (al_dat),
    .ill    (al_ill)
  );

  assign pend_rd = pend.rd[AW-1:0];
  assign wait_st = (state == WAIT);

  // The load response owns the write port in its cycle, so execute yields.
  assign ex_rdy = !(wait_st && (ex_ld || ld_vld ||
                                (ex_wen && pend.we && ex_rd == pend_rd)));
  assign ex_acc = ex_vld && ex_rdy;

  assign id_stall = wait_st && pend.we &&
                    ((id_e_rs1 && id_rs1 == pend_rd) ||
                     (id_e_rs2 && id_rs2 == pend_rd));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pend   <= '0;
      e_rd   <= 1'b0;
      a_rd   <= '0;
      d_rd   <= '0;
      ld_err <= 1'b0;
    end else begin
      e_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_vld)
            ld_err <= 1'b1;
          if (ex_acc) begin
            if (ex_ld) begin
              state    <= WAIT;
              pend.we  <= ex_wen && (ex_rd != '0);
              pend.rd  <= 5'(ex_rd);
              pend.f3  <= ex_f3;
              pend.off <= ex_off;
            end else if (ex_wen) begin
              e_rd <= 1'b1;
              a_rd <= ex_rd;
              d_rd <= ex_dat;
            end
          end
        end
        WAIT: begin
          if (ld_vld) begin
            state <= IDLE;
            if (al_ill)
              ld_err <= 1'b1;
            if (pend.we) begin
              e_rd <= 1'b1;
              a_rd <= pend_rd;
              d_rd <= al_dat;
            end
          end else if (ex_acc && ex_wen) begin
            e_rd <= 1'b1;
            a_rd <= ex_rd;
            d_rd <= ex_dat;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
